id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Parametrised successor to the combinational decode stage. It performs RV32I decode, immediate generation, operand selection and, new in this block, holds the results in a registered ID/EX pipeline stage.
- Adds a valid/ready handshake on both sides, load-use interlock with bubble insertion, flush, an illegal-opcode flag and a saturating stall counter.
- Sits between the IF/ID register and EX. It drives register-file read addresses and receives the read data combinationally in the same cycle.

Parameters:
- XLEN, 32, datapath width for PC, operands and immediate.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_valid  in  1  IF/ID holds a valid instruction.
- o_ready  out  1  stage accepts the instruction this cycle.
- i_instruct  in  32  instruction word.
- i_pc  in  XLEN  PC of the instruction.
- o_rs1, o_rs2  out  5 each  combinational RF read addresses, i_instruct[19:15] and [24:20].
- i_regData1, i_regData2  in  XLEN  RF read data.
- i_flush  in  1  kill the incoming instruction and the EX-register contents.
- o_valid  out  1  ID/EX register holds a valid instruction.
- i_ready  in  1  EX accepts this cycle.
- o_jal, o_jalr, o_branch, o_MemRead, o_MemWrite, o_RegWrite, o_illegal  out  1 each  registered control.
- o_Data_sel  out  2  writeback select: 00 ALU, 01 memory, 10 PC+4.
- o_ALUop  out  3  000 add, 001 branch compare, 010 R-type, 011 I-ALU, 100 pass op2.
- o_op1, o_op2, o_imm, o_Rdata2, o_pc  out  XLEN  registered operands, immediate, store data, PC.
- o_rd  out  5  destination register.
- o_func  out  4  {instr[30], instr[14:12]}.
- o_func3  out  3  instr[14:12].
- o_stall_cnt  out  CNT_W  count of load-use stall cycles.
- i_wb_en  in  1  writeback write enable; only present under FWD_EN.
- i_wb_rd  in  5  writeback destination; only present under FWD_EN.
- i_wb_data  in  XLEN  writeback data; only present under FWD_EN.

Behaviour:
- Reset (rst=0, asynchronous): every registered output goes to 0, including o_valid and o_stall_cnt. o_ready=0 while rst=0.
- ex_free = !o_valid | i_ready.
- hazard = o_valid & o_MemRead & (o_rd!=0) & ((o_rd==rs1 & uses_rs1) | (o_rd==rs2 & uses_rs2)).
  - uses_rs1: R, I-ALU, load, store, branch, jalr.
  - uses_rs2: R, store, branch.
- o_ready = rst & (i_flush | (ex_free & !hazard)). Combinational.
- Per edge, evaluated in priority order:
  1. i_flush: o_valid<=0; the incoming instruction is consumed and dropped. Flush wins over stall and over load.
  2. ex_free & hazard: bubble. o_valid<=0, control bits <=0, o_stall_cnt increments and saturates at all-ones.
  3. ex_free & i_valid: load the decoded instruction, o_valid<=1.
  4. ex_free & !i_valid: o_valid<=0.
  5. Otherwise: hold all registers.
- Latency: one cycle from acceptance to o_valid.
- Decode by opcode:
  - R 0110011: RegWrite, ALUop 010.
  - I-ALU 0010011: RegWrite, op2=imm, ALUop 011.
  - Load 0000011: MemRead, RegWrite, Data_sel 01, op2=imm, ALUop 000.
  - Store 0100011: MemWrite, op2=imm, ALUop 000.
  - Branch 1100011: branch, op1=pc, op2=imm, ALUop 000.
  - JAL 1101111: jal, RegWrite, Data_sel 10, op1=pc, op2=imm, ALUop 000.
  - JALR 1100111: jalr, RegWrite, Data_sel 10, op2=imm, ALUop 000.
  - LUI 0110111: RegWrite, op1=0, op2=imm, ALUop 100.
  - AUIPC 0010111: RegWrite, op1=pc, op2=imm, ALUop 000.
  - Any other opcode: o_illegal=1, all other control bits 0, o_valid=1 so EX can trap.
- Immediates (I/S/B/U/J per RV32I) are sign-extended to XLEN. U-type is {instr[31:12], 12'b0} sign-extended.
- o_rd = instr[11:7], forced to 0 when RegWrite=0.
- With XLEN>32, the PC and all immediates are sign-extended.

Optional Feature:
- Macro: ID_EX_WB_FWD_EN.
- When defined: the WB ports exist. If i_wb_en & i_wb_rd!=0 & i_wb_rd==rs1, i_wb_data replaces i_regData1 before operand selection; the same rule applies to rs2, o_Rdata2 and o_op2.
- When undefined: the WB ports are absent and operands come only from the RF; the RF is required to write-through.

Test Plan:
- Reset/idle: hold rst=0, then release with i_valid=0 → all outputs 0; o_ready=1 from the first cycle after release.
- ADDI: instr 0x00500093 (addi x1,x0,5), i_regData1=0, i_ready=1 → next cycle o_valid=1, o_op2=5, o_ALUop=011, o_rd=1, o_RegWrite=1.
- Load-use: lw x2,0(x1) (0x0000A103) followed by add x3,x2,x2 (0x002101B3) → one bubble (o_valid=0, o_ready=0 for one cycle), o_stall_cnt=1, then the add issues.
- Backpressure: i_ready=0 for 3 cycles with a valid instr held → outputs stable, o_ready=0; the stage advances on the cycle i_ready returns to 1.
- Flush during hazard: hazard active and i_flush=1 → o_ready=1, next cycle o_valid=0, o_stall_cnt unchanged.
- Illegal/forwarding:
  - Opcode 0x7F → o_illegal=1, RegWrite=0.
  - Under ID_EX_WB_FWD_EN: i_wb_rd=1, i_wb_data=0xDEADBEEF, i_regData1=0 with add x3,x1,x0 → o_op1=0xDEADBEEF.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode, immediate generation and operand selection,
// with the result held in a registered ID/EX stage. Valid/ready handshake on
// both sides, load-use interlock with bubble insertion, flush, illegal-opcode
// flag and a saturating stall counter.
// Optional build macro: ID_EX_WB_FWD_EN adds WB->ID operand forwarding ports;
// without it operands come straight from a write-through register file.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instruct,
    input  logic [XLEN-1:0]  i_pc,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    input  logic [XLEN-1:0]  i_regData1,
    input  logic [XLEN-1:0]  i_regData2,
    input  logic             i_flush,
`ifdef ID_EX_WB_FWD_EN
    input  logic             i_wb_en,
    input  logic [4:0]       i_wb_rd,
    input  logic [XLEN-1:0]  i_wb_data,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_jal,
    output logic             o_jalr,
    output logic             o_branch,
    output logic             o_MemRead,
    output logic             o_MemWrite,
    output logic             o_RegWrite,
    output logic             o_illegal,
    output logic [1:0]       o_Data_sel,
    output logic [2:0]       o_ALUop,
    output logic [XLEN-1:0]  o_op1,
    output logic [XLEN-1:0]  o_op2,
    output logic [XLEN-1:0]  o_imm,
    output logic [XLEN-1:0]  o_Rdata2,
    output logic [XLEN-1:0]  o_pc,
    output logic [4:0]       o_rd,
    output logic [3:0]       o_func,
    output logic [2:0]       o_func3,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IALU   = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;

    logic [6:0]        opcode;
    logic              d_jal, d_jalr, d_branch, d_mem_read, d_mem_write;
    logic              d_reg_write, d_illegal, d_op2_imm, uses_rs1, uses_rs2;
    logic [1:0]        d_data_sel;
    logic [2:0]        d_alu_op;
    op1_sel_e          d_op1_sel;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]   imm_x, rs1_data, rs2_data, d_op1, d_op2;
    logic [4:0]        d_rd;
    logic              ex_free, hazard;

    assign opcode = i_instruct[6:0];
    assign o_rs1  = i_instruct[19:15];
    assign o_rs2  = i_instruct[24:20];

`ifdef ID_EX_WB_FWD_EN
    assign rs1_data = (i_wb_en && i_wb_rd != 5'd0 && i_wb_rd == o_rs1) ? i_wb_data : i_regData1;
    assign rs2_data = (i_wb_en && i_wb_rd != 5'd0 && i_wb_rd == o_rs2) ? i_wb_data : i_regData2;
`else
    assign rs1_data = i_regData1;
    assign rs2_data = i_regData2;
`endif

    // Decode opcode into control bits, immediate format and operand sources.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        d_jal       = 1'b0;
        d_jalr      = 1'b0;
        d_branch    = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_reg_write = 1'b0;
        d_illegal   = 1'b0;
        d_op2_imm   = 1'b0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        d_data_sel  = 2'b00;
        d_alu_op    = 3'b000;
        d_op1_sel   = OP1_RS1;
        imm32       = {{20{i_instruct[31]}}, i_instruct[31:20]};
        case (opcode)
            OP_R:      begin d_reg_write = 1'b1; d_alu_op = 3'b010; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_IALU:   begin d_reg_write = 1'b1; d_alu_op = 3'b011; d_op2_imm = 1'b1; uses_rs1 = 1'b1; end
            OP_LOAD:   begin d_mem_read = 1'b1; d_reg_write = 1'b1; d_data_sel = 2'b01;
                             d_op2_imm = 1'b1; uses_rs1 = 1'b1; end
            OP_STORE:  begin d_mem_write = 1'b1; d_op2_imm = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                             imm32 = {{20{i_instruct[31]}}, i_instruct[31:25], i_instruct[11:7]}; end
            OP_BRANCH: begin d_branch = 1'b1; d_op1_sel = OP1_PC; d_op2_imm = 1'b1;
                             uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                             imm32 = {{19{i_instruct[31]}}, i_instruct[31], i_instruct[7],
                                      i_instruct[30:25], i_instruct[11:8], 1'b0}; end
            OP_JAL:    begin d_jal = 1'b1; d_reg_write = 1'b1; d_data_sel = 2'b10;
                             d_op1_sel = OP1_PC; d_op2_imm = 1'b1;
                             imm32 = {{11{i_instruct[31]}}, i_instruct[31], i_instruct[19:12],
                                      i_instruct[20], i_instruct[30:21], 1'b0}; end
            OP_JALR:   begin d_jalr = 1'b1; d_reg_write = 1'b1; d_data_sel = 2'b10;
                             d_op2_imm = 1'b1; uses_rs1 = 1'b1; end
            OP_LUI:    begin d_reg_write = 1'b1; d_alu_op = 3'b100; d_op1_sel = OP1_ZERO;
                             d_op2_imm = 1'b1; imm32 = {i_instruct[31:12], 12'b0}; end
            OP_AUIPC:  begin d_reg_write = 1'b1; d_op1_sel = OP1_PC; d_op2_imm = 1'b1;
                             imm32 = {i_instruct[31:12], 12'b0}; end
            default:   d_illegal = 1'b1;
        endcase
    end

    // Sign-extend the immediate and pick the two ALU operands.
    always_comb begin
        imm_x = XLEN'(imm32);
        case (d_op1_sel)
            OP1_PC:   d_op1 = i_pc;
            OP1_ZERO: d_op1 = '0;
            default:  d_op1 = rs1_data;
        endcase
        d_op2 = d_op2_imm ? imm_x : rs2_data;
        d_rd  = d_reg_write ? i_instruct[11:7] : 5'd0;
    end

    // Load-use interlock against the load currently held for EX, and handshake.
    assign ex_free = !o_valid || i_ready;
    assign hazard  = o_valid && o_MemRead && (o_rd != 5'd0) &&
                     ((o_rd == o_rs1 && uses_rs1) || (o_rd == o_rs2 && uses_rs2));
    assign o_ready = rst && (i_flush || (ex_free && !hazard));

    // ID/EX register: flush, then bubble, then load, then drain, else hold.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            o_valid <= 1'b0; o_jal <= 1'b0; o_jalr <= 1'b0; o_branch <= 1'b0;
            o_MemRead <= 1'b0; o_MemWrite <= 1'b0; o_RegWrite <= 1'b0; o_illegal <= 1'b0;
            o_Data_sel <= '0; o_ALUop <= '0; o_op1 <= '0; o_op2 <= '0; o_imm <= '0;
            o_Rdata2 <= '0; o_pc <= '0; o_rd <= '0; o_func <= '0; o_func3 <= '0;
            o_stall_cnt <= '0;
        end else if (i_flush || (ex_free && hazard)) begin
            o_valid <= 1'b0; o_jal <= 1'b0; o_jalr <= 1'b0; o_branch <= 1'b0;
            o_MemRead <= 1'b0; o_MemWrite <= 1'b0; o_RegWrite <= 1'b0; o_illegal <= 1'b0;
            o_Data_sel <= '0; o_ALUop <= '0; o_rd <= '0;
            if (!i_flush && o_stall_cnt != '1)
                o_stall_cnt <= o_stall_cnt + 1'b1;
        end else if (ex_free && i_valid) begin
            o_valid <= 1'b1; o_jal <= d_jal; o_jalr <= d_jalr; o_branch <= d_branch;
            o_MemRead <= d_mem_read; o_MemWrite <= d_mem_write; o_RegWrite <= d_reg_write;
            o_illegal <= d_illegal; o_Data_sel <= d_data_sel; o_ALUop <= d_alu_op;
            o_op1 <= d_op1; o_op2 <= d_op2; o_imm <= imm_x; o_Rdata2 <= rs2_data;
            o_pc <= i_pc; o_rd <= d_rd;
            o_func <= {i_instruct[30], i_instruct[14:12]};
            o_func3 <= i_instruct[14:12];
        end else if (ex_free) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized bench for id_ex_stage with a
// transaction-level reference model of the decode rules and stage register.
module tb_id_ex_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0, rst = 1'b0;
    logic i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b0;
    logic [31:0] i_instruct = '0;
    logic [XLEN-1:0] i_pc = '0, i_regData1 = '0, i_regData2 = '0;
    logic o_ready, o_valid, o_jal, o_jalr, o_branch, o_MemRead, o_MemWrite, o_RegWrite, o_illegal;
    logic [4:0] o_rs1, o_rs2, o_rd;
    logic [1:0] o_Data_sel;
    logic [2:0] o_ALUop, o_func3;
    logic [3:0] o_func;
    logic [XLEN-1:0] o_op1, o_op2, o_imm, o_Rdata2, o_pc;
    logic [CNT_W-1:0] o_stall_cnt;
`ifdef ID_EX_WB_FWD_EN
    logic i_wb_en = 1'b0;
    logic [4:0] i_wb_rd = '0;
    logic [XLEN-1:0] i_wb_data = '0;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_instruct(i_instruct), .i_pc(i_pc), .o_rs1(o_rs1), .o_rs2(o_rs2),
        .i_regData1(i_regData1), .i_regData2(i_regData2), .i_flush(i_flush),
`ifdef ID_EX_WB_FWD_EN
        .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
`endif
        .o_valid(o_valid), .i_ready(i_ready), .o_jal(o_jal), .o_jalr(o_jalr),
        .o_branch(o_branch), .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite),
        .o_RegWrite(o_RegWrite), .o_illegal(o_illegal), .o_Data_sel(o_Data_sel),
        .o_ALUop(o_ALUop), .o_op1(o_op1), .o_op2(o_op2), .o_imm(o_imm),
        .o_Rdata2(o_Rdata2), .o_pc(o_pc), .o_rd(o_rd), .o_func(o_func),
        .o_func3(o_func3), .o_stall_cnt(o_stall_cnt)
    );

    // Expected content of the stage register; *_k flags mark fields the model defines.
    typedef struct {
        bit valid, jal, jalr, branch, mem_read, mem_write, reg_write, illegal;
        bit [1:0] data_sel;
        bit [2:0] alu_op, func3;
        bit [3:0] func;
        bit [4:0] rd;
        bit [31:0] op1, op2, imm, rdata2, pc;
        bit full_k, op1_k, op2_k, imm_k, ctl_zero;
    } exp_t;

    exp_t m;
    int m_cnt = 0;
    int n_checks = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which source registers an instruction reads.
    function automatic void ref_uses(input logic [31:0] ins, output bit u1, output bit u2);
        u1 = 0; u2 = 0;
        case (ins[6:0])
            7'b0110011, 7'b0100011, 7'b1100011: begin u1 = 1; u2 = 1; end
            7'b0010011, 7'b0000011, 7'b1100111: u1 = 1;
            default: ;
        endcase
    endfunction

    // Expected stage content for one accepted instruction.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] d1, input logic [31:0] d2);
        exp_t e;
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, b_hi, j_hi;
        e = '{default: 0};
        i_imm = $signed(ins) >>> 20;
        b_hi  = $signed(ins & 32'h8000_0000) >>> 19;
        j_hi  = $signed(ins & 32'h8000_0000) >>> 11;
        s_imm = (i_imm & ~32'h1F) | 32'(ins[11:7]);
        b_imm = b_hi | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        u_imm = ins & 32'hFFFF_F000;
        j_imm = j_hi | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        e.valid = 1; e.full_k = 1; e.op1_k = 1; e.op2_k = 1; e.imm_k = 1;
        case (ins[6:0])
            7'b0110011: begin e.reg_write = 1; e.alu_op = 2; e.op1 = d1; e.op2 = d2; e.imm_k = 0; end
            7'b0010011: begin e.reg_write = 1; e.alu_op = 3; e.op1 = d1; e.imm = i_imm; end
            7'b0000011: begin e.mem_read = 1; e.reg_write = 1; e.data_sel = 1; e.op1 = d1; e.imm = i_imm; end
            7'b0100011: begin e.mem_write = 1; e.op1 = d1; e.imm = s_imm; end
            7'b1100011: begin e.branch = 1; e.op1 = pc; e.imm = b_imm; end
            7'b1101111: begin e.jal = 1; e.reg_write = 1; e.data_sel = 2; e.op1 = pc; e.imm = j_imm; end
            7'b1100111: begin e.jalr = 1; e.reg_write = 1; e.data_sel = 2; e.op1 = d1; e.imm = i_imm; end
            7'b0110111: begin e.reg_write = 1; e.alu_op = 4; e.op1 = 0; e.imm = u_imm; end
            7'b0010111: begin e.reg_write = 1; e.op1 = pc; e.imm = u_imm; end
            default:    begin e.illegal = 1; e.op1_k = 0; e.op2_k = 0; e.imm_k = 0; end
        endcase
        if (ins[6:0] != 7'b0110011) e.op2 = e.imm;
        e.rdata2 = d2;
        e.pc     = pc;
        e.rd     = e.reg_write ? ins[11:7] : 5'd0;
        e.func   = {ins[30], ins[14:12]};
        e.func3  = ins[14:12];
        return e;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".valid"}, o_valid, m.valid);
        chk({tag, ".stall_cnt"}, o_stall_cnt, m_cnt);
        if (m.ctl_zero) begin
            chk({tag, ".ctl"}, {o_jal, o_jalr, o_branch, o_MemRead, o_MemWrite, o_RegWrite, o_illegal}, 0);
        end
        if (m.full_k) begin
            chk({tag, ".ctl"}, {o_jal, o_jalr, o_branch, o_MemRead, o_MemWrite, o_RegWrite, o_illegal},
                {m.jal, m.jalr, m.branch, m.mem_read, m.mem_write, m.reg_write, m.illegal});
            chk({tag, ".data_sel"}, o_Data_sel, m.data_sel);
            chk({tag, ".alu_op"}, o_ALUop, m.alu_op);
            chk({tag, ".rd"}, o_rd, m.rd);
            chk({tag, ".func"}, {o_func, o_func3}, {m.func, m.func3});
            chk({tag, ".pc"}, o_pc, m.pc);
            chk({tag, ".rdata2"}, o_Rdata2, m.rdata2);
            if (m.op1_k) chk({tag, ".op1"}, o_op1, m.op1);
            if (m.op2_k) chk({tag, ".op2"}, o_op2, m.op2);
            if (m.imm_k) chk({tag, ".imm"}, o_imm, m.imm);
        end
    endtask

    // One clock: check combinational outputs, advance the model, check the register.
    task automatic cycle(input string tag);
        bit u1, u2, haz, ex_free, exp_ready;
        logic [4:0] rs1, rs2;
        logic [31:0] d1, d2;
        #1;
        rs1 = i_instruct[19:15];
        rs2 = i_instruct[24:20];
        d1 = i_regData1;
        d2 = i_regData2;
`ifdef ID_EX_WB_FWD_EN
        if (i_wb_en && i_wb_rd != 0 && i_wb_rd == rs1) d1 = i_wb_data;
        if (i_wb_en && i_wb_rd != 0 && i_wb_rd == rs2) d2 = i_wb_data;
`endif
        ref_uses(i_instruct, u1, u2);
        ex_free = !m.valid || i_ready;
        haz = m.valid && m.mem_read && m.rd != 0 && ((m.rd == rs1 && u1) || (m.rd == rs2 && u2));
        exp_ready = rst && (i_flush || (ex_free && !haz));
        chk({tag, ".ready"}, o_ready, exp_ready);
        chk({tag, ".rs"}, {o_rs1, o_rs2}, {rs1, rs2});
        if (i_flush) begin
            m.valid = 0; m.full_k = 0; m.ctl_zero = 0;
        end else if (ex_free && haz) begin
            m.valid = 0; m.full_k = 0; m.ctl_zero = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (ex_free && i_valid) begin
            m = ref_decode(i_instruct, i_pc, d1, d2);
        end else if (ex_free) begin
            m.valid = 0; m.full_k = 0; m.ctl_zero = 0;
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] d1, input logic [31:0] d2, input logic rdy, input logic fl);
        i_valid = v; i_instruct = ins; i_pc = pc; i_regData1 = d1; i_regData2 = d2;
        i_ready = rdy; i_flush = fl;
    endtask

    logic [6:0] op_tab [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};

    initial begin
        logic [31:0] ins;
        // Reset held: outputs cleared, not ready even with a valid request.
        drive(1, 32'h0050_0093, 32'h100, 0, 0, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", o_ready, 0);
        chk("rst.valid", o_valid, 0);
        chk("rst.cnt", o_stall_cnt, 0);
        chk("rst.regs", {o_op1, o_op2, o_imm, o_rd, o_RegWrite, o_ALUop}, 0);
        m = '{default: 0};
        m.full_k = 1; m.op1_k = 1; m.op2_k = 1; m.imm_k = 1;
        i_valid = 0;
        rst = 1;
        cycle("idle");

        // ADDI x1, x0, 5.
        drive(1, 32'h0050_0093, 32'h100, 0, 0, 1, 0);
        cycle("addi");
        chk("addi.op2", o_op2, 5);
        chk("addi.alu", o_ALUop, 3'b011);
        chk("addi.rd", o_rd, 1);
        chk("addi.rw", {o_valid, o_RegWrite}, 2'b11);

        // Load-use: lw x2,0(x1) then add x3,x2,x2 -> one bubble.
        drive(1, 32'h0000_A103, 32'h104, 32'h40, 0, 1, 0);
        cycle("lw");
        drive(1, 32'h0021_01B3, 32'h108, 7, 7, 1, 0);
        #1 chk("lu.ready", o_ready, 0);
        cycle("lu.bubble");
        chk("lu.cnt", o_stall_cnt, 1);
        chk("lu.valid", o_valid, 0);
        cycle("lu.issue");
        chk("lu.add_rd", o_rd, 3);

        // Backpressure: addi x5 in EX, addi x6 waits three cycles.
        drive(1, 32'h0050_0293, 32'h200, 0, 0, 1, 0);
        cycle("bp.first");
        drive(1, 32'h0070_0313, 32'h204, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp.ready", o_ready, 0);
            cycle("bp.hold");
            chk("bp.rd", o_rd, 5);
        end
        i_ready = 1;
        cycle("bp.release");
        chk("bp.rd_new", o_rd, 6);

        // Flush while a load-use hazard is pending.
        drive(1, 32'h0000_A103, 32'h300, 32'h80, 0, 1, 0);
        cycle("fl.lw");
        drive(1, 32'h0021_01B3, 32'h304, 1, 1, 1, 1);
        #1 chk("fl.ready", o_ready, 1);
        cycle("fl.flush");
        chk("fl.cnt", o_stall_cnt, 1);

        // Illegal opcode.
        drive(1, 32'h0000_007F, 32'h400, 0, 0, 1, 0);
        cycle("ill");
        chk("ill.flags", {o_valid, o_illegal, o_RegWrite}, 3'b110);

`ifdef ID_EX_WB_FWD_EN
        drive(1, 32'h0000_81B3, 32'h500, 0, 0, 1, 0);
        i_wb_en = 1; i_wb_rd = 1; i_wb_data = 32'hDEAD_BEEF;
        cycle("fwd");
        chk("fwd.op1", o_op1, 32'hDEAD_BEEF);
        i_wb_en = 0;
`endif

        // Drive the stall counter into saturation with repeated load-use pairs.
        for (int k = 0; k < 20; k++) begin
            drive(1, 32'h0000_A103, 32'h600, 0, 0, 1, 0);
            cycle("sat.lw");
            drive(1, 32'h0021_01B3, 32'h604, 0, 0, 1, 0);
            cycle("sat.bubble");
            cycle("sat.add");
        end
        chk("sat.cnt", o_stall_cnt, CNT_MAX);

        // Randomized traffic over a small register window to provoke hazards.
        for (int k = 0; k < 400; k++) begin
            ins = $urandom;
            ins[6:0] = op_tab[$urandom_range(0, 9)];
            ins[11:7] = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 3) != 0), ins, $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) == 0));
`ifdef ID_EX_WB_FWD_EN
            i_wb_en = 1'($urandom_range(0, 1));
            i_wb_rd = 5'($urandom_range(0, 3));
            i_wb_data = $urandom;
`endif
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
